// File: rtl/demod_pkg.sv
//==============================================================================
// Module   : demod_pkg
// Brief    : Shared types, constants and helpers for the ASK/QAM demodulators.
// Revision : 1.0
//==============================================================================
`default_nettype none

package demod_pkg;

  localparam int THR_STEP_DEF = 40;
  localparam int LVL_W_MAX    = 8;

  typedef logic [LVL_W_MAX-1:0] lvl_idx_t;

  function automatic lvl_idx_t gray_enc(input lvl_idx_t k);
    return k ^ (k >> 1);
  endfunction

  // Counter width able to hold 0..win inclusive.
  function automatic int count_w(input int win);
    return $clog2(win + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/argmax_tie_low.sv
//==============================================================================
// Module   : argmax_tie_low
// Brief    : Combinational N-input maximum; ties resolve to the lowest index.
// Revision : 1.0
//==============================================================================
`default_nettype none

module argmax_tie_low #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N*W-1:0] i_vals,
  output logic [IW-1:0]  o_idx,
  output logic [W-1:0]   o_val
);

  // Strict greater-than keeps the earliest index on equal counts.
  always_comb begin
    o_val = i_vals[W-1:0];
    o_idx = '0;
    for (int i = 1; i < N; i++) begin
      if (i_vals[i*W +: W] > o_val) begin
        o_val = i_vals[i*W +: W];
        o_idx = IW'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/demod_mask.sv
//==============================================================================
// Module   : demod_mask
// Brief    : M-ary ASK demodulator, sliding-window majority vote per strobe.
//            Define DEMOD_MASK_GRAY_EN for Gray-coded symbol output.
// Revision : 1.0
//==============================================================================
`default_nettype none

module demod_mask
  import demod_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LEVELS   = 4,
  parameter int WIN      = 200,
  parameter int THR_STEP = THR_STEP_DEF
) (
  input  logic                        clk_carrier,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           filt_data,
  input  logic                        sym_strobe,
  output logic [$clog2(LEVELS)-1:0]   symbol,
  output logic                        sym_valid,
  output logic [count_w(WIN)-1:0]     sym_conf
);

  localparam int SW   = $clog2(LEVELS);
  localparam int CW   = count_w(WIN);
  localparam int CMPW = DATA_W + SW + 1;
  localparam int JMAX = LEVELS / 2 - 1;

  logic signed [CMPW-1:0] w_data_ext;
  logic signed [CMPW-1:0] w_bound;
  logic [SW-1:0]          w_k;
  logic                   w_full;
  logic [LEVELS*CW-1:0]   w_cnt_flat;
  logic [SW-1:0]          w_max_idx;
  logic [CW-1:0]          w_max_val;
  logic [SW-1:0]          w_sym_enc;

  logic [SW-1:0]          r_hist [WIN];
  logic [CW-1:0]          r_fill;
  logic [SW-1:0]          r_symbol;
  logic [CW-1:0]          r_conf;
  logic                   r_valid;

  // Widened so that the outermost boundary can never wrap.
  assign w_data_ext = {{(CMPW-DATA_W){filt_data[DATA_W-1]}}, filt_data};

  always_comb begin
    w_k     = '0;
    w_bound = '0;
    for (int j = -JMAX; j <= JMAX; j++) begin
      w_bound = CMPW'(j * THR_STEP);
      if (w_data_ext > w_bound) begin
        w_k = w_k + 1'b1;
      end
    end
  end

  assign w_full = (r_fill == CW'(WIN));

  always_ff @(posedge clk_carrier or posedge rst) begin
    if (rst) begin
      r_fill <= '0;
      for (int i = 0; i < WIN; i++) begin
        r_hist[i] <= '0;
      end
    end else if (in_valid) begin
      if (!w_full) begin
        r_fill <= r_fill + 1'b1;
      end
      r_hist[0] <= w_k;
      for (int i = 1; i < WIN; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
    end
  end

  // r_hist[WIN-1] is the sample leaving the window once it is full.
  for (genvar l = 0; l < LEVELS; l++) begin : g_cnt
    logic [CW-1:0] r_cnt;
    logic          w_inc;
    logic          w_dec;

    assign w_inc = in_valid && (w_k == SW'(l));
    assign w_dec = in_valid && w_full && (r_hist[WIN-1] == SW'(l));

    always_ff @(posedge clk_carrier or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end

    assign w_cnt_flat[l*CW +: CW] = r_cnt;
  end

  argmax_tie_low #(
    .N  (LEVELS),
    .W  (CW),
    .IW (SW)
  ) u_argmax (
    .i_vals (w_cnt_flat),
    .o_idx  (w_max_idx),
    .o_val  (w_max_val)
  );

`ifdef DEMOD_MASK_GRAY_EN
  assign w_sym_enc = SW'(gray_enc(lvl_idx_t'(w_max_idx)));
`else
  assign w_sym_enc = w_max_idx;
`endif

  always_ff @(posedge clk_carrier or posedge rst) begin
    if (rst) begin
      r_symbol <= '0;
      r_conf   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (sym_strobe && w_full) begin
        r_valid  <= 1'b1;
        r_symbol <= w_sym_enc;
        r_conf   <= w_max_val;
      end
    end
  end

  assign symbol    = r_symbol;
  assign sym_conf  = r_conf;
  assign sym_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_demod_mask.sv
//==============================================================================
// Module   : tb_demod_mask
// Brief    : Self-checking bench for demod_mask (LEVELS=4, WIN=8, THR_STEP=40).
//            Honours DEMOD_MASK_GRAY_EN when selecting expected symbols.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_demod_mask;

  localparam int DATA_W = 8;
  localparam int LEVELS = 4;
  localparam int WIN    = 8;
  localparam int THR    = 40;

  logic        clk_carrier = 1'b0;
  logic        rst         = 1'b1;
  logic        in_valid    = 1'b0;
  logic [7:0]  filt_data   = '0;
  logic        sym_strobe  = 1'b0;
  logic [1:0]  symbol;
  logic        sym_valid;
  logic [3:0]  sym_conf;

  demod_mask #(
    .DATA_W   (DATA_W),
    .LEVELS   (LEVELS),
    .WIN      (WIN),
    .THR_STEP (THR)
  ) dut (
    .clk_carrier (clk_carrier),
    .rst         (rst),
    .in_valid    (in_valid),
    .filt_data   (filt_data),
    .sym_strobe  (sym_strobe),
    .symbol      (symbol),
    .sym_valid   (sym_valid),
    .sym_conf    (sym_conf)
  );

  always #5 clk_carrier = ~clk_carrier;

  typedef struct {
    int val_a; int n_a; int val_b; int n_b;
    int exp_nat; int exp_gray; int exp_conf;
  } vec_t;

  typedef struct {
    logic [1:0] sym;
    logic [3:0] conf;
  } exp_t;

  vec_t vecs [10];
  exp_t sb [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   p0;

  function automatic logic [1:0] pick(input int nat, input int gray);
`ifdef DEMOD_MASK_GRAY_EN
    return 2'(gray);
`else
    return 2'(nat);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk_carrier) begin
    if (!rst && sym_valid) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got sym_valid=1 symbol=%0d conf=%0d, expected no pulse",
                 symbol, sym_conf);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_symbol", int'(symbol), int'(mon_e.sym));
        chk("sb_conf", int'(sym_conf), int'(mon_e.conf));
      end
    end
  end

  task automatic step();
    @(posedge clk_carrier);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic feed(input int val, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b1;
      filt_data = 8'(val);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_dec(input int nat, input int gray, input int conf);
    exp_t e;
    e.sym  = pick(nat, gray);
    e.conf = 4'(conf);
    sb.push_back(e);
  endtask

  task automatic strobe_expect(input int nat, input int gray, input int conf);
    expect_dec(nat, gray, conf);
    sym_strobe = 1'b1;
    step();
    sym_strobe = 1'b0;
  endtask

  task automatic drain(input string name);
    step();
    step();
    chk(name, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{100,  8,    0, 0, 3, 2, 8};
    vecs[1] = '{0,    8,    0, 0, 1, 1, 8};
    vecs[2] = '{-40,  8,    0, 0, 0, 0, 8};
    vecs[3] = '{40,   8,    0, 0, 2, 3, 8};
    vecs[4] = '{41,   8,    0, 0, 3, 2, 8};
    vecs[5] = '{-39,  8,    0, 0, 1, 1, 8};
    vecs[6] = '{-100, 4,   10, 4, 0, 0, 4};
    vecs[7] = '{-100, 8,  100, 5, 3, 2, 5};
    vecs[8] = '{10,   3, -100, 5, 0, 0, 5};
    vecs[9] = '{127,  8,    0, 0, 3, 2, 8};

    step();
    chk("reset_symbol", int'(symbol), 0);
    chk("reset_conf", int'(sym_conf), 0);
    chk("reset_valid", int'(sym_valid), 0);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      reset_dut();
      feed(vecs[v].val_a, vecs[v].n_a);
      feed(vecs[v].val_b, vecs[v].n_b);
      strobe_expect(vecs[v].exp_nat, vecs[v].exp_gray, vecs[v].exp_conf);
      drain("vec_drain");
    end

    // Strobe coincident with a new sample sees the pre-sample counts.
    reset_dut();
    feed(-100, 8);
    feed(100, 5);
    expect_dec(3, 2, 5);
    sym_strobe = 1'b1;
    in_valid   = 1'b1;
    filt_data  = 8'(100);
    step();
    in_valid = 1'b0;
    strobe_expect(3, 2, 6);
    drain("same_cycle_drain");

    // Stall then back-to-back strobes; outputs hold between strobes.
    reset_dut();
    feed(100, 8);
    repeat (20) step();
    p0 = pulses;
    expect_dec(3, 2, 8);
    expect_dec(3, 2, 8);
    sym_strobe = 1'b1;
    step();
    step();
    sym_strobe = 1'b0;
    drain("b2b_drain");
    chk("b2b_pulses", pulses - p0, 2);
    repeat (5) step();
    chk("hold_symbol", int'(symbol), int'(pick(3, 2)));
    chk("hold_conf", int'(sym_conf), 8);

    // Asynchronous reset mid-fill, then a partial window must not decide.
    feed(-100, 3);
    rst = 1'b1;
    #1;
    chk("async_rst_symbol", int'(symbol), 0);
    chk("async_rst_conf", int'(sym_conf), 0);
    chk("async_rst_valid", int'(sym_valid), 0);
    step();
    rst = 1'b0;
    feed(100, 5);
    p0 = pulses;
    sym_strobe = 1'b1;
    step();
    sym_strobe = 1'b0;
    step();
    step();
    chk("partial_no_pulse", pulses - p0, 0);
    chk("partial_symbol", int'(symbol), 0);
    chk("partial_conf", int'(sym_conf), 0);
    feed(100, 3);
    strobe_expect(3, 2, 8);
    drain("refill_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
